sd_spi_card_responder: RTL and testbench
========================================

Name: sd_spi_card_responder

Overview:
- Synthesizable SPI-mode SD card responder: the card end of the SD_CLK/SD_CS/SD_DATAOUT/SD_DATAIN link driven by the MCU SD controller.
- Used in simulation benches and in loopback FPGA test builds. Receives 48-bit command frames and returns R1/R3/R7 responses.
- Serves CMD17 single-block reads from a byte-wide sector memory port, using SDHC block addressing.
- Runs in the HCLK domain and oversamples SD_CLK.

Parameters:
- SYNC_STAGES, 2, flop stages on SD_CLK, SD_CS and MOSI.
- NCR_BYTES, 1, 0xFF bytes sent between the command CRC byte and the first response byte (range 1..8).
- NAC_BYTES, 2, 0xFF bytes sent between the CMD17 R1 and the data token 0xFE (range 1..255).
- ACMD41_BUSY, 2, number of ACMD41 calls that return 0x01 before the card leaves idle.
- OCR_VALUE, 32'hC0FF8000, OCR returned by CMD58 (CCS=1).

Ports:
- HCLK  in  1  system clock; must be at least 4x the SD_CLK frequency.
- hwRstn  in  1  asynchronous active-low reset.
- sd_clk  in  1  SPI clock from the host, mode 0.
- sd_cs_n  in  1  chip select, active low.
- sd_mosi  in  1  host-to-card data; connects to the host's SD_DATAOUT.
- sd_miso  out  1  card-to-host data; connects to the host's SD_DATAIN.
- mem_rd_en  out  1  sector memory read strobe, one HCLK pulse.
- mem_addr  out  32  byte address: {arg[22:0], 9'b0} + offset.
- mem_rdata  in  8  read data, valid exactly 1 HCLK after mem_rd_en.
- card_idle  out  1  idle-state flag; equals R1 bit0.
- cmd_strobe  out  1  one-cycle pulse when a full 6-byte command has been received.
- cmd_index  out  6  index of the last received command.

Behaviour:
- Reset values: sd_miso=1, mem_rd_en=0, mem_addr=0, card_idle=1, cmd_strobe=0, cmd_index=0, acmd41 counter=0, app_cmd flag=0. FSM state is WAIT_CMD.
- Edge detection: sd_clk is synchronized, then compared with its previous value.
  - Rising edge: shift in the synced MOSI.
  - Falling edge: shift out the next MISO bit, MSB first.
  - Bit 7 of each transmitted byte is loaded on the falling edge that ends the previous byte.
- Bit counter: 3 bits, wraps 7 to 0. A byte is complete on the 8th rising edge.
- sd_cs_n high (synced), in any state:
  - Go to WAIT_CMD, clear the bit counter, drive sd_miso=1.
  - card_idle, the app_cmd flag and the acmd41 counter are kept.
- FSM states:
  - WAIT_CMD: a received byte with [7:6]=2'b01 starts a command. cmd_index takes [5:0]; go to RX_ARG. Any other byte is ignored.
  - RX_ARG: collect 4 argument bytes and 1 CRC byte. The CRC is ignored. Pulse cmd_strobe, then go to NCR.
  - NCR: send NCR_BYTES of 0xFF, then go to RESP.
  - RESP: send R1, then the trailing bytes if any. Go to NAC for CMD17 with R1=0x00; otherwise go to WAIT_CMD.
  - NAC: send NAC_BYTES of 0xFF, then go to TOKEN.
  - TOKEN: send 0xFE, then go to DATA.
  - DATA: send 512 bytes from memory, offset 0..511, then go to CRC.
  - CRC: send 0xFF, 0xFF, then go to WAIT_CMD.
- Command decode (R1 bit0 = card_idle value after the command executes):
  - CMD0: card_idle=1, app_cmd=0, acmd41 counter=0. R1=0x01.
  - CMD8: R7 = 0x01|idle, then 0x00, 0x00, 0x01, arg[7:0].
  - CMD55: set app_cmd. R1=idle.
  - ACMD41 (CMD41 with app_cmd set):
    - If counter < ACMD41_BUSY: increment the counter, R1=0x01.
    - Otherwise: card_idle=0, R1=0x00.
  - CMD58: R3 = R1, then OCR_VALUE MSB first.
  - CMD17 while idle: R1=0x05, no data phase.
  - CMD17 while not idle: R1=0x00, then the data phase.
  - Any other command: R1=0x04|idle.
  - app_cmd clears after any command other than CMD55.
- Memory prefetch:
  - For DATA byte n, pulse mem_rd_en at the first rising edge of the preceding byte (the last NAC/TOKEN byte, or DATA byte n-1).
  - Capture mem_rdata 1 HCLK later into the next-byte register.
  - Fetch exactly 512 times; offset wraps 511 to 0 only at the end of the block.
- Commands are not received while sending: MOSI is ignored outside WAIT_CMD and RX_ARG. A host abort must use sd_cs_n.

Decomposition:
- Shared package sd_spi_pkg holds:
  - command index constants: CMD0, CMD8, CMD17, CMD41, CMD55, CMD58;
  - R1 bit constants: IDLE=0x01, ILLEGAL=0x04;
  - the token constant 0xFE;
  - the FSM state enum.
- One sub-module: sd_spi_edge_sync. It synchronizes sd_clk, sd_cs_n and sd_mosi and emits rise/fall pulses.

Test Plan:
- After reset, CMD0 frame 40 00 00 00 00 95 -> one 0xFF, then R1 0x01; cmd_strobe pulses once with cmd_index=0.
- CMD8 with arg 0x000001AA -> 01 00 00 01 AA.
- CMD55+ACMD41 repeated -> 0x01, 0x01, then 0x00 on the 3rd call; card_idle falls. A following CMD58 -> 00 C0 FF 80 00.
- CMD17 with arg 5 after init, memory preloaded with byte = addr[7:0] -> R1 00, FF FF, FE.
  - 512 bytes 00..FF,00..FF follow, then FF FF.
  - mem_addr runs 0xA00..0xBFF; 512 mem_rd_en pulses.
- CMD17 sent while idle -> R1 0x05 and no token. CMD13 -> R1 0x04|idle.
- sd_cs_n raised at DATA byte 100 -> sd_miso=1 within SYNC_STAGES+1 HCLK. A subsequent CMD58 is answered normally and card_idle stays 0.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SPI-mode SD card responder.
// Holds the command indices the card understands, the R1 flag bits,
// the single-block data start token and the byte-level FSM state type.
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam logic [7:0] R1_IDLE    = 8'h01;
  localparam logic [7:0] R1_ILLEGAL = 8'h04;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;

  // Each state names the kind of byte currently on the wire.
  typedef enum logic [2:0] {
    ST_WAIT_CMD,
    ST_RX_ARG,
    ST_NCR,
    ST_RESP,
    ST_NAC,
    ST_TOKEN,
    ST_DATA,
    ST_CRC
  } sd_state_t;

endpackage

// File: rtl/sd_spi_edge_sync.sv
// Brings the host SPI pins into the HCLK domain and detects SD_CLK edges.
// Ports:
//   HCLK, hwRstn         system clock, asynchronous active-low reset
//   sd_clk/sd_cs_n/sd_mosi  raw host pins
//   clk_rise, clk_fall   one-HCLK pulses on synchronized SD_CLK edges
//   cs_n_s, mosi_s       synchronized chip select and MOSI
module sd_spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic hwRstn,
  input  logic sd_clk,
  input  logic sd_cs_n,
  input  logic sd_mosi,
  output logic clk_rise,
  output logic clk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   clk_prev;

  // Chip select resets deasserted so the card starts out deselected.
  always_ff @(posedge HCLK or negedge hwRstn) begin
    if (!hwRstn) begin
      clk_sr   <= '0;
      cs_sr    <= '1;
      mosi_sr  <= '1;
      clk_prev <= 1'b0;
    end else begin
      clk_sr[0]  <= sd_clk;
      cs_sr[0]   <= sd_cs_n;
      mosi_sr[0] <= sd_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sr[i]  <= clk_sr[i-1];
        cs_sr[i]   <= cs_sr[i-1];
        mosi_sr[i] <= mosi_sr[i-1];
      end
      clk_prev <= clk_sr[SYNC_STAGES-1];
    end
  end

  assign clk_rise = clk_sr[SYNC_STAGES-1] & ~clk_prev;
  assign clk_fall = ~clk_sr[SYNC_STAGES-1] & clk_prev;
  assign cs_n_s   = cs_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card model (card side of the link), oversampling SD_CLK in HCLK.
// Receives 48-bit commands, answers with R1/R3/R7, and serves CMD17 single
// block reads from a byte-wide memory using SDHC block addressing.
// Ports:
//   HCLK, hwRstn      system clock (>= 4x SD_CLK), async active-low reset
//   sd_clk, sd_cs_n   host SPI clock (mode 0) and chip select
//   sd_mosi, sd_miso  host-to-card and card-to-host data
//   mem_rd_en         one-HCLK read strobe to the sector memory
//   mem_addr          byte address {arg[22:0], 9'b0} + offset
//   mem_rdata         read data, valid one HCLK after mem_rd_en
//   card_idle         idle-state flag (R1 bit 0)
//   cmd_strobe        pulse when a complete 6-byte command has arrived
//   cmd_index         index of the last received command
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          NCR_BYTES   = 1,
  parameter int          NAC_BYTES   = 2,
  parameter int          ACMD41_BUSY = 2,
  parameter logic [31:0] OCR_VALUE   = 32'hC0FF8000
) (
  input  logic        HCLK,
  input  logic        hwRstn,
  input  logic        sd_clk,
  input  logic        sd_cs_n,
  input  logic        sd_mosi,
  output logic        sd_miso,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        card_idle,
  output logic        cmd_strobe,
  output logic [5:0]  cmd_index
);

  localparam logic [7:0] NCR_LAST = 8'(NCR_BYTES - 1);
  localparam logic [7:0] NAC_LAST = 8'(NAC_BYTES - 1);
  localparam logic [7:0] BUSY_LIM = 8'(ACMD41_BUSY);

  logic clk_rise, clk_fall, cs_n_s, mosi_s;

  sd_spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .HCLK     (HCLK),
    .hwRstn   (hwRstn),
    .sd_clk   (sd_clk),
    .sd_cs_n  (sd_cs_n),
    .sd_mosi  (sd_mosi),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s)
  );

  sd_state_t   state_q, state_d;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_shift;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_shift;
  logic [7:0]  tx_byte;
  logic [2:0]  arg_cnt;
  logic [22:0] cmd_arg;
  logic [7:0]  wait_cnt;
  logic [39:0] resp_buf;
  logic [2:0]  resp_idx, resp_len;
  logic        data_pending;
  logic [8:0]  data_cnt, fetch_off;
  logic [7:0]  next_byte;
  logic        rd_en_q;
  logic        app_cmd;
  logic [7:0]  acmd41_cnt;
  logic        byte_done, byte_start, fetch;

  logic        dec_idle, dec_app, dec_data;
  logic [7:0]  dec_acmd, dec_r1;
  logic [31:0] dec_tail;
  logic [2:0]  dec_len;

  // A byte is complete on the 8th rising edge; the 1st rising edge of a
  // byte is where the memory fetch for the byte after it is issued.
  assign rx_byte    = {rx_shift, mosi_s};
  assign byte_done  = clk_rise & ~cs_n_s & (bit_cnt == 3'd7);
  assign byte_start = clk_rise & ~cs_n_s & (bit_cnt == 3'd0);

  // Command execution: the new card state and the response bytes that the
  // command produces, evaluated when the CRC byte completes.
  always_comb begin
    dec_idle = card_idle;
    dec_app  = 1'b0;
    dec_acmd = acmd41_cnt;
    dec_r1   = R1_ILLEGAL | {7'd0, card_idle};
    dec_tail = 32'd0;
    dec_len  = 3'd1;
    dec_data = 1'b0;
    case (cmd_index)
      CMD0: begin
        dec_idle = 1'b1;
        dec_acmd = 8'd0;
        dec_r1   = R1_IDLE;
      end
      CMD8: begin
        dec_r1   = R1_IDLE | {7'd0, card_idle};
        dec_tail = {24'h000001, cmd_arg[7:0]};
        dec_len  = 3'd5;
      end
      CMD55: begin
        dec_app = 1'b1;
        dec_r1  = {7'd0, card_idle};
      end
      CMD41: begin
        if (app_cmd) begin
          if (acmd41_cnt < BUSY_LIM) begin
            dec_acmd = acmd41_cnt + 8'd1;
            dec_r1   = R1_IDLE;
          end else begin
            dec_idle = 1'b0;
            dec_r1   = 8'h00;
          end
        end
      end
      CMD58: begin
        dec_r1   = {7'd0, card_idle};
        dec_tail = OCR_VALUE;
        dec_len  = 3'd5;
      end
      CMD17: begin
        if (card_idle) begin
          dec_r1 = R1_ILLEGAL | R1_IDLE;
        end else begin
          dec_r1   = 8'h00;
          dec_data = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic; the state advances only on byte completion so that it
  // always describes the byte to be loaded at the following falling edge.
  always_comb begin
    state_d = state_q;
    tx_byte = 8'hFF;
    fetch   = 1'b0;
    case (state_q)
      ST_RESP:  tx_byte = resp_buf[39:32];
      ST_TOKEN: tx_byte = DATA_TOKEN;
      ST_DATA:  tx_byte = next_byte;
      default:  tx_byte = 8'hFF;
    endcase
    if (byte_start && (state_q == ST_TOKEN ||
                       (state_q == ST_DATA && data_cnt != 9'd511))) begin
      fetch = 1'b1;
    end
    if (cs_n_s) begin
      state_d = ST_WAIT_CMD;
    end else if (byte_done) begin
      case (state_q)
        ST_WAIT_CMD: if (rx_byte[7:6] == 2'b01) state_d = ST_RX_ARG;
        ST_RX_ARG:   if (arg_cnt == 3'd4) state_d = ST_NCR;
        ST_NCR:      if (wait_cnt == NCR_LAST) state_d = ST_RESP;
        ST_RESP: begin
          if (resp_idx == resp_len - 3'd1) begin
            state_d = data_pending ? ST_NAC : ST_WAIT_CMD;
          end
        end
        ST_NAC:      if (wait_cnt == NAC_LAST) state_d = ST_TOKEN;
        ST_TOKEN:    state_d = ST_DATA;
        ST_DATA:     if (data_cnt == 9'd511) state_d = ST_CRC;
        ST_CRC:      if (wait_cnt == 8'd1) state_d = ST_WAIT_CMD;
        default:     state_d = ST_WAIT_CMD;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge HCLK or negedge hwRstn) begin
    if (!hwRstn) begin
      state_q <= ST_WAIT_CMD;
    end else begin
      state_q <= state_d;
    end
  end

  // Serial datapath, command bookkeeping and memory prefetch. Deselect only
  // aborts the transfer; card_idle, app_cmd and the ACMD41 count survive it.
  always_ff @(posedge HCLK or negedge hwRstn) begin
    if (!hwRstn) begin
      sd_miso      <= 1'b1;
      mem_rd_en    <= 1'b0;
      mem_addr     <= 32'd0;
      card_idle    <= 1'b1;
      cmd_strobe   <= 1'b0;
      cmd_index    <= 6'd0;
      bit_cnt      <= 3'd0;
      rx_shift     <= 7'd0;
      tx_shift     <= 8'hFF;
      arg_cnt      <= 3'd0;
      cmd_arg      <= 23'd0;
      wait_cnt     <= 8'd0;
      resp_buf     <= 40'd0;
      resp_idx     <= 3'd0;
      resp_len     <= 3'd1;
      data_pending <= 1'b0;
      data_cnt     <= 9'd0;
      fetch_off    <= 9'd0;
      next_byte    <= 8'hFF;
      rd_en_q      <= 1'b0;
      app_cmd      <= 1'b0;
      acmd41_cnt   <= 8'd0;
    end else begin
      cmd_strobe <= 1'b0;
      mem_rd_en  <= 1'b0;
      rd_en_q    <= mem_rd_en;
      if (rd_en_q) begin
        next_byte <= mem_rdata;
      end
      if (cs_n_s) begin
        bit_cnt  <= 3'd0;
        sd_miso  <= 1'b1;
        tx_shift <= 8'hFF;
      end else begin
        if (clk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
        end
        // bit_cnt of zero at a falling edge marks the end of a byte, so the
        // MSB of the next byte goes out here.
        if (clk_fall) begin
          if (bit_cnt == 3'd0) begin
            sd_miso  <= tx_byte[7];
            tx_shift <= {tx_byte[6:0], 1'b1};
          end else begin
            sd_miso  <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b1};
          end
        end
        if (fetch) begin
          mem_rd_en <= 1'b1;
          mem_addr  <= {cmd_arg, 9'd0} + {23'd0, fetch_off};
          fetch_off <= fetch_off + 9'd1;
        end
        if (byte_done) begin
          wait_cnt <= (state_d != state_q) ? 8'd0 : wait_cnt + 8'd1;
          case (state_q)
            ST_WAIT_CMD: begin
              if (rx_byte[7:6] == 2'b01) begin
                cmd_index <= rx_byte[5:0];
                arg_cnt   <= 3'd0;
              end
            end
            ST_RX_ARG: begin
              if (arg_cnt == 3'd4) begin
                cmd_strobe   <= 1'b1;
                card_idle    <= dec_idle;
                app_cmd      <= dec_app;
                acmd41_cnt   <= dec_acmd;
                resp_buf     <= {dec_r1, dec_tail};
                resp_len     <= dec_len;
                resp_idx     <= 3'd0;
                data_pending <= dec_data;
                fetch_off    <= 9'd0;
                data_cnt     <= 9'd0;
              end else begin
                cmd_arg <= {cmd_arg[14:0], rx_byte};
                arg_cnt <= arg_cnt + 3'd1;
              end
            end
            ST_RESP: begin
              resp_buf <= {resp_buf[31:0], 8'hFF};
              resp_idx <= resp_idx + 3'd1;
            end
            ST_DATA:  data_cnt <= data_cnt + 9'd1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Self-checking bench for sd_spi_card_responder. A mode-0 SPI host drives
// command frames; a behavioural card model predicts every returned byte.
`timescale 1ns/1ps
module tb_sd_spi_card_responder;

  localparam int          SYNC_STAGES = 2;
  localparam int          NCR_BYTES   = 1;
  localparam int          NAC_BYTES   = 2;
  localparam int          ACMD41_BUSY = 2;
  localparam logic [31:0] OCR_VALUE   = 32'hC0FF8000;
  localparam int          HALF        = 4;

  logic        HCLK = 1'b0;
  logic        hwRstn;
  logic        sd_clk, sd_cs_n, sd_mosi;
  logic        sd_miso, mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        card_idle, cmd_strobe;
  logic [5:0]  cmd_index;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [31:0] rd_addrs[$];

  // Card model state
  logic        m_idle = 1'b1;
  logic        m_app = 1'b0;
  int          m_acmd = 0;
  logic [7:0]  exp_resp[$];
  logic        exp_data;

  sd_spi_card_responder #(
    .SYNC_STAGES(SYNC_STAGES), .NCR_BYTES(NCR_BYTES), .NAC_BYTES(NAC_BYTES),
    .ACMD41_BUSY(ACMD41_BUSY), .OCR_VALUE(OCR_VALUE)
  ) dut (
    .HCLK(HCLK), .hwRstn(hwRstn), .sd_clk(sd_clk), .sd_cs_n(sd_cs_n),
    .sd_mosi(sd_mosi), .sd_miso(sd_miso), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .card_idle(card_idle),
    .cmd_strobe(cmd_strobe), .cmd_index(cmd_index)
  );

  always #5 HCLK = ~HCLK;

  // Sector memory: every byte holds the low 8 bits of its own address.
  always @(posedge HCLK) if (mem_rd_en) mem_rdata <= mem_addr[7:0];

  always @(negedge HCLK) begin
    if (cmd_strobe) strobe_cnt++;
    if (mem_rd_en) rd_addrs.push_back(mem_addr);
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sd_mosi = b;
    repeat (HALF) @(negedge HCLK);
    r = sd_miso;
    sd_clk = 1'b1;
    repeat (HALF) @(negedge HCLK);
    sd_clk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  // Predicts the response bytes and state change for one command.
  task automatic model_cmd(input int idx, input logic [31:0] arg);
    logic prev_app;
    prev_app = m_app;
    m_app = 1'b0;
    exp_resp.delete();
    exp_data = 1'b0;
    case (idx)
      0: begin m_idle = 1'b1; m_acmd = 0; exp_resp.push_back(8'h01); end
      8: begin
        exp_resp.push_back(8'h01);
        exp_resp.push_back(8'h00);
        exp_resp.push_back(8'h00);
        exp_resp.push_back(8'h01);
        exp_resp.push_back(arg[7:0]);
      end
      55: begin m_app = 1'b1; exp_resp.push_back(m_idle ? 8'h01 : 8'h00); end
      41: begin
        if (!prev_app) exp_resp.push_back(m_idle ? 8'h05 : 8'h04);
        else if (m_acmd < ACMD41_BUSY) begin m_acmd++; exp_resp.push_back(8'h01); end
        else begin m_idle = 1'b0; exp_resp.push_back(8'h00); end
      end
      58: begin
        exp_resp.push_back(m_idle ? 8'h01 : 8'h00);
        for (int i = 3; i >= 0; i--) exp_resp.push_back(8'((OCR_VALUE >> (8 * i)) & 32'hFF));
      end
      17: begin
        if (m_idle) exp_resp.push_back(8'h05);
        else begin exp_resp.push_back(8'h00); exp_data = 1'b1; end
      end
      default: exp_resp.push_back(m_idle ? 8'h05 : 8'h04);
    endcase
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] r;
    logic [7:0] frame[6];
    frame[0] = {2'b01, idx};
    frame[1] = arg[31:24];
    frame[2] = arg[23:16];
    frame[3] = arg[15:8];
    frame[4] = arg[7:0];
    frame[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'h01;
    for (int i = 0; i < 6; i++) begin
      spi_xfer(frame[i], r);
      check("frame_miso", {24'd0, r}, 32'hFF);
    end
    for (int i = 0; i < NCR_BYTES; i++) begin
      spi_xfer(8'hFF, r);
      check("ncr", {24'd0, r}, 32'hFF);
    end
  endtask

  task automatic read_to_token();
    logic [7:0] r;
    for (int i = 0; i < NAC_BYTES; i++) begin
      spi_xfer(8'hFF, r);
      check("nac", {24'd0, r}, 32'hFF);
    end
    spi_xfer(8'hFF, r);
    check("token", {24'd0, r}, 32'hFE);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] r;
    logic [31:0] base;
    int s0;
    base = {arg[22:0], 9'd0};
    model_cmd(int'(idx), arg);
    s0 = strobe_cnt;
    rd_addrs.delete();
    send_frame(idx, arg);
    foreach (exp_resp[i]) begin
      spi_xfer(8'hFF, r);
      check("resp", {24'd0, r}, {24'd0, exp_resp[i]});
    end
    check("strobe_count", strobe_cnt - s0, 1);
    check("cmd_index", {26'd0, cmd_index}, {26'd0, idx});
    check("card_idle", {31'd0, card_idle}, {31'd0, m_idle});
    if (exp_data) begin
      read_to_token();
      for (int n = 0; n < 512; n++) begin
        spi_xfer(8'hFF, r);
        check("data", {24'd0, r}, (base + n) & 32'hFF);
      end
      for (int i = 0; i < 2; i++) begin
        spi_xfer(8'hFF, r);
        check("data_crc", {24'd0, r}, 32'hFF);
      end
      check("fetch_count", rd_addrs.size(), 512);
      foreach (rd_addrs[i]) check("fetch_addr", rd_addrs[i], base + i);
    end else if (idx == 6'd17) begin
      for (int i = 0; i < NAC_BYTES + 2; i++) begin
        spi_xfer(8'hFF, r);
        check("no_token", {24'd0, r}, 32'hFF);
      end
    end
  endtask

  // Starts a block read, aborts it with chip select in the middle of data
  // byte 100 and checks that MISO returns high within the sync latency.
  task automatic abort_read(input logic [31:0] arg);
    logic [7:0] r;
    logic [7:0] exp100;
    logic b;
    logic [31:0] base;
    base = {arg[22:0], 9'd0};
    model_cmd(17, arg);
    send_frame(6'd17, arg);
    spi_xfer(8'hFF, r);
    check("abort_r1", {24'd0, r}, {24'd0, exp_resp[0]});
    read_to_token();
    for (int n = 0; n < 100; n++) begin
      spi_xfer(8'hFF, r);
      check("abort_data", {24'd0, r}, (base + n) & 32'hFF);
    end
    exp100 = 8'((base + 100) & 32'hFF);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    repeat (HALF) @(negedge HCLK);
    check("miso_before_cs", {31'd0, sd_miso}, {31'd0, exp100[3]});
    sd_cs_n = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge HCLK);
    #1;
    check("miso_after_cs", {31'd0, sd_miso}, 32'd1);
    repeat (8) @(negedge HCLK);
    sd_cs_n = 1'b0;
    repeat (8) @(negedge HCLK);
  endtask

  initial begin
    int pick;
    int rnd_cmds[7];
    rnd_cmds = '{0, 8, 13, 24, 41, 55, 58};
    hwRstn  = 1'b0;
    sd_cs_n = 1'b1;
    sd_clk  = 1'b0;
    sd_mosi = 1'b1;
    repeat (3) @(negedge HCLK);
    hwRstn = 1'b1;
    @(negedge HCLK);
    check("rst_miso", {31'd0, sd_miso}, 32'd1);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_idle", {31'd0, card_idle}, 32'd1);
    check("rst_strobe", {31'd0, cmd_strobe}, 32'd0);
    check("rst_index", {26'd0, cmd_index}, 32'd0);
    sd_cs_n = 1'b0;
    repeat (8) @(negedge HCLK);

    run_cmd(6'd0, 32'h0);
    run_cmd(6'd8, 32'h000001AA);
    run_cmd(6'd8, {20'd0, 4'h1, 8'($urandom_range(0, 255))});
    run_cmd(6'd13, $urandom);
    run_cmd(6'd17, 32'd3);
    for (int k = 0; k <= ACMD41_BUSY; k++) begin
      run_cmd(6'd55, 32'h0);
      run_cmd(6'd41, 32'h40000000);
    end
    run_cmd(6'd58, 32'h0);
    run_cmd(6'd17, 32'd5);
    run_cmd(6'd13, 32'h0);
    abort_read($urandom & 32'h007FFFFF);
    run_cmd(6'd58, 32'h0);
    for (int k = 0; k < 5; k++) begin
      pick = $urandom_range(0, 6);
      run_cmd(6'(rnd_cmds[pick]), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
